// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall unit of the 5-stage MIPS pipeline.
// Contents:
//   - scoreboard stage indices (EX, MEM, WB)
//   - forwarding select encodings driven to the EX operand muxes
//   - scoreboard entry record {v, rd, ld} plus match / priority helpers
package hazard_stall_unit_pkg;

  localparam int STAGE_EX   = 0;
  localparam int STAGE_MEM  = 1;
  localparam int STAGE_WB   = 2;
  localparam int NUM_STAGES = 3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // One in-flight writer: valid, destination register, is-a-load.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{v: 1'b0, rd: 5'd0, ld: 1'b0};

  // True when the slot holds a live writer of register r.
  function automatic logic sb_match(input sb_entry_t e, input logic [4:0] r);
    return e.v & (e.rd == r);
  endfunction

  // Youngest producer wins: the EX/MEM copy is newer than the MEM/WB copy.
  function automatic logic [1:0] fwd_pick(input logic hit_near, input logic hit_far);
    logic [1:0] sel;
    if (hit_near) begin
      sel = FWD_EXMEM;
    end else if (hit_far) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One pipeline slot of the destination-register scoreboard.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high clear
//   i_d      : entry arriving from the previous slot (or from ID)
//   o_q      : entry currently held by this slot
module hazard_scoreboard_entry
  import hazard_stall_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  sb_entry_t i_d,
  output sb_entry_t o_q
);

  sb_entry_t r_entry;

  // Slot register; reset empties the slot so no stale writer can hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry <= SB_EMPTY;
    end else begin
      r_entry <= i_d;
    end
  end

  assign o_q = r_entry;

endmodule

// File: rtl/hazard_stall_unit.sv
// RAW hazard detection, stall/bubble generation and EX forwarding selects.
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   id_*                : decoded fields of the instruction sitting in ID
//   r1_used, r2_used    : ID instruction actually reads rs / rt
//   flush               : taken branch/jump squashes the ID instruction
//   stall               : hold PC and IF/ID (combinational)
//   id_ex_bubble        : load a NOP into ID/EX at the next edge
//   fwd_a_sel/fwd_b_sel : registered EX operand sources (valid while the
//                         instruction is in EX)
//   stall_cycles        : saturating count of stalled cycles
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             r1_used,
  input  logic             r2_used,
  input  logic             id_wr_en,
  input  logic [4:0]       id_wr_reg,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  sb_entry_t                w_e [NUM_STAGES];
  sb_entry_t                w_ex_d;
  logic [NUM_STAGES-1:0]    w_hit_a;
  logic [NUM_STAGES-1:0]    w_hit_b;
  logic                     w_hazard;
  logic                     w_issue;
  logic [1:0]               w_fwd_a_nxt;
  logic [1:0]               w_fwd_b_nxt;
  logic                     w_unused_ld;
  logic [1:0]               r_fwd_a;
  logic [1:0]               r_fwd_b;
  logic [CNT_W-1:0]         r_stall_cycles;

  // Per-slot source hits, already qualified by whether the operand is read.
  always_comb begin
    w_hit_a = '0;
    w_hit_b = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_hit_a[k] = r1_used & sb_match(w_e[k], id_rs);
      w_hit_b[k] = r2_used & sb_match(w_e[k], id_rt);
    end
  end

  // With forwarding only a load still in EX cannot supply its result in time.
  always_comb begin
    w_hazard = 1'b0;
    if (FWD_EN) begin
      w_hazard = w_e[STAGE_EX].ld & (w_hit_a[STAGE_EX] | w_hit_b[STAGE_EX]);
    end else begin
      w_hazard = (|w_hit_a) | (|w_hit_b);
    end
  end

  // flush dominates stall: the squashed instruction becomes the bubble.
  assign stall        = id_valid & ~flush & w_hazard;
  assign id_ex_bubble = stall | flush;
  assign w_issue      = id_valid & ~stall & ~flush;

  // Entry pushed into EX; writes to $0 are recorded as invalid.
  always_comb begin
    w_ex_d = SB_EMPTY;
    if (w_issue) begin
      w_ex_d.v  = id_wr_en & (id_wr_reg != REG_ZERO);
      w_ex_d.rd = id_wr_reg;
      w_ex_d.ld = id_is_load;
    end else begin
      w_ex_d = SB_EMPTY;
    end
  end

  hazard_scoreboard_entry u_slot_ex (
    .clk (clk),
    .rst (rst),
    .i_d (w_ex_d),
    .o_q (w_e[STAGE_EX])
  );

  hazard_scoreboard_entry u_slot_mem (
    .clk (clk),
    .rst (rst),
    .i_d (w_e[STAGE_EX]),
    .o_q (w_e[STAGE_MEM])
  );

  hazard_scoreboard_entry u_slot_wb (
    .clk (clk),
    .rst (rst),
    .i_d (w_e[STAGE_MEM]),
    .o_q (w_e[STAGE_WB])
  );

  // Load flags matter only in EX; older slots keep them just to shift.
  assign w_unused_ld = w_e[STAGE_MEM].ld ^ w_e[STAGE_WB].ld;

  // Selects computed in ID against the slots the producers will occupy
  // one stage further on, so they line up with the consumer reaching EX.
  always_comb begin
    w_fwd_a_nxt = FWD_RF;
    w_fwd_b_nxt = FWD_RF;
    if (w_issue && FWD_EN && r1_used) begin
      w_fwd_a_nxt = fwd_pick(sb_match(w_e[STAGE_EX], id_rs), sb_match(w_e[STAGE_MEM], id_rs));
    end else begin
      w_fwd_a_nxt = FWD_RF;
    end
    if (w_issue && FWD_EN && r2_used) begin
      w_fwd_b_nxt = fwd_pick(sb_match(w_e[STAGE_EX], id_rt), sb_match(w_e[STAGE_MEM], id_rt));
    end else begin
      w_fwd_b_nxt = FWD_RF;
    end
  end

  // Forwarding select registers (bubbles carry FWD_RF).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else begin
      r_fwd_a <= w_fwd_a_nxt;
      r_fwd_b <= w_fwd_b_nxt;
    end
  end

  // Saturating stall-cycle counter; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= {CNT_W{1'b0}};
    end else if (stall && (r_stall_cycles != CNT_MAX)) begin
      r_stall_cycles <= r_stall_cycles + CNT_ONE;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign fwd_a_sel    = r_fwd_a;
  assign fwd_b_sel    = r_fwd_b;
  assign stall_cycles = r_stall_cycles;

endmodule
